// File: rtl/dmem_pkg.sv
// Shared definitions for the latency-configurable data memory: funct3 encodings and FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for the data memory: store byte mask/data, load
// extraction with sign/zero extension, and the alignment/unsupported-funct3 flags.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  be,
  input  logic [1:0]  lo,
  input  logic [31:0] wd,
  input  logic [31:0] word,
  output logic [3:0]  lane_mask,
  output logic [31:0] lane_data,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        unsupported
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lo, 3'b000} +: 8];
  assign half_sel = word[{lo[1], 4'b0000} +: 16];

  always_comb begin
    lane_mask   = 4'b0000;
    lane_data   = '0;
    load_data   = '0;
    misalign    = 1'b0;
    unsupported = 1'b0;
    case (be)
      F3_B, F3_BU: begin
        lane_mask = 4'b0001 << lo;
        lane_data = {4{wd[7:0]}};
        load_data = be[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        // a[0] is ignored for lane choice; it only matters for the fault flag
        lane_mask = lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wd[15:0]}};
        load_data = be[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misalign  = lo[0];
      end
      F3_W: begin
        lane_mask = 4'b1111;
        lane_data = wd;
        load_data = word;
        misalign  = |lo;
      end
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_lat.sv
// Data memory with configurable access latency and req/busy/done handshake.
// Optional fault reporting on misaligned accesses: define DMEM_MISALIGN_EN.
module dmem_lat
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [2:0]  be,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic accept, commit;

  logic        we_reg;
  logic [AW+1:0] a_reg;
  logic [31:0] wd_reg;
  logic [2:0]  be_reg;

  logic        cur_we;
  logic [AW+1:0] cur_a;
  logic [31:0] cur_wd;
  logic [2:0]  cur_be;
  logic [AW-1:0] cur_idx;

  logic [31:0] mem [DEPTH_WORDS];

  logic [3:0]  lane_mask;
  logic [31:0] lane_data, load_data;
  logic        misalign, unsupported, fault;

  // With LATENCY=1 the commit edge is the accept edge, so the live inputs are used.
  always_comb begin
    if (state == IDLE) begin
      cur_we = we;
      cur_a  = a[AW+1:0];
      cur_wd = wd;
      cur_be = be;
    end else begin
      cur_we = we_reg;
      cur_a  = a_reg;
      cur_wd = wd_reg;
      cur_be = be_reg;
    end
  end

  assign cur_idx = cur_a[AW+1:2];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept     = 1'b1;
        cnt_next   = CNT_INIT;
        state_next = (LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign commit = (state_next == DONE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_reg <= 1'b0;
      a_reg  <= '0;
      wd_reg <= '0;
      be_reg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      if (accept) begin
        we_reg <= we;
        a_reg  <= a[AW+1:0];
        wd_reg <= wd;
        be_reg <= be;
      end
    end
  end

  dmem_align u_align (
    .be          (cur_be),
    .lo          (cur_a[1:0]),
    .wd          (cur_wd),
    .word        (mem[cur_idx]),
    .lane_mask   (lane_mask),
    .lane_data   (lane_data),
    .load_data   (load_data),
    .misalign    (misalign),
    .unsupported (unsupported)
  );

`ifdef DMEM_MISALIGN_EN
  logic err_reg;
  assign fault = unsupported | misalign;
  assign err   = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_reg <= 1'b0;
    else if (commit) err_reg <= fault;
  end
`else
  logic unused_misalign;
  assign fault           = unsupported;
  assign err             = 1'b0;
  assign unused_misalign = misalign;
`endif

  // Stores leave rd untouched; loads and faulted accesses overwrite it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
    end else if (commit && (!cur_we || fault)) begin
      rd <= fault ? '0 : load_data;
    end
  end

  // Array contents survive reset; reset only blocks the pending commit.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[cur_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^a[31:AW+2];

endmodule

// File: doc/dmem_lat.md
# dmem_lat

Parametrised successor to the single-cycle data memory behind the RISC-V pipeline. It adds:
- a configurable access latency with a req/busy/done handshake, so the pipeline can stall on memory;
- funct3-driven byte, half and word stores;
- load extraction with sign/zero extension.

It sits between the MEM stage and the backing store. The pipeline holds MEM while `busy` is high.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥4.
- `LATENCY`, 2: cycles from accept edge to `done` cycle; ≥1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; sampled only when `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `a`  in  32  byte address.
- `wd`  in  32  store data; low byte/half used for sb/sh.
- `be`  in  3  funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `busy`  out  1  access in flight; new requests ignored.
- `done`  out  1  one-cycle completion pulse.
- `rd`  out  32  load result; valid in the `done` cycle, held until the next `done`.
- `err`  out  1  access fault; valid with `done`.

## Operation
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT (LATENCY>1) or → DONE (LATENCY=1) on `req`=1; latch `we`, `a`, `wd`, `be`; load a counter with LATENCY-2.
  - WAIT: decrement the counter; → DONE when it reaches 0.
  - DONE → IDLE unconditionally. No accept in DONE, so throughput is one access per LATENCY+1 cycles.
- Commit and capture happen on the edge entering DONE:
  - Store: write masked lanes into the array.
  - Load: capture the extracted value into `rd`.
- Word index = `a[2 +: log2(DEPTH_WORDS)]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- Store lanes:
  - sb: lane `a[1:0]` receives `wd[7:0]`.
  - sh: lanes {2·a[1], 2·a[1]+1} receive `wd[15:0]`.
  - sw: all four lanes.
- Loads:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Lane selection matches stores.
- Unsupported funct3 (011, 110, 111): write suppressed, `rd`=0. `err`=1 only when the macro below is defined.
- `req` while `busy`=1 is dropped; there is no queue.
- Reset mid-access: return to IDLE at once and discard the pending write. The array contents are not reset.

## Timing
- Reset values: `busy`=0, `done`=0, `rd`=0, `err`=0, state IDLE.
- Accept edge k. `busy`=1 in cycles k+1 … k+LATENCY. `done`=1 only in cycle k+LATENCY.
- `busy` and `done` are registered; no combinational path from `req` to them.
- `err` is registered alongside `rd`.

## Configuration
- `DMEM_MISALIGN_EN` defined:
  - These accesses are faults: lh/lhu/sh with `a[0]`=1; lw/sw with `a[1:0]`≠0; unsupported funct3.
  - A fault suppresses the write, sets `rd`=0, and sets `err`=1 in the `done` cycle.
- `DMEM_MISALIGN_EN` undefined:
  - Half accesses ignore `a[0]`; word accesses ignore `a[1:0]`.
  - Unsupported funct3 behaves as described in Operation.
  - `err` is tied to 0.

## Structure
- Package `dmem_pkg` holds the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
- Sub-module `dmem_align`, purely combinational, provides:
  - store lane mask and lane data from (`be`, `a[1:0]`, `wd`);
  - load extraction from (`be`, `a[1:0]`, word);
  - the misalign flag.
- `dmem_lat` holds the FSM, the counter, the latched request and the array.

## Test plan
- LATENCY=2, sw 0xDEADBEEF @0x10 accepted at cycle 0 → `busy`=1 in cycles 1–2, `done` only in cycle 2. Then lw @0x10 → `rd`=0xDEADBEEF, `err`=0.
- sb `wd`=0x80 @0x13 → lb @0x13 = 0xFFFFFF80; lbu @0x13 = 0x00000080; lw @0x10 = 0x80ADBEEF.
- sh 0x8001 @0x12 → lh @0x12 = 0xFFFF8001; lhu @0x12 = 0x00008001; lw @0x10 = 0x8001BEEF.
- lw @0x11:
  - macro defined → `err`=1, `rd`=0.
  - macro undefined → `rd` = word @0x10, `err`=0.
  - sw @0x11 with macro defined leaves memory unchanged.
- Reset asserted in cycle 1 of sw 0x11111111 @0x20 → `busy`/`done` drop asynchronously. A following lw @0x20 returns the prior contents.
- `req` held high for 6 cycles with LATENCY=2 → exactly two `done` pulses, in cycles 2 and 5. sw @(4·DEPTH_WORDS) then lw @0x0 → same data (wrap).
